// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared encodings for the iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // Default operand / HI / LO width
  localparam int DATA_W_DEF = 32;

  // Operation encodings carried on op_i
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // Sequencer states
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_CALC = 2'd1;
  localparam mdu_state_t ST_SIGN = 2'd2;

  // Signed ops are the even encodings (MULT, DIV)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Divide ops have the upper encoding bit set
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_cond_neg.sv
`default_nettype none
// ============================================================================
// Module : mdu_cond_neg
// Brief  : Conditional two's-complement negate, y = neg ? -a : a.
// Rev    : 1.0  initial release
// ============================================================================
module mdu_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_i
);

  assign y_i = neg_i ? -a_i : a_i;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module : mult_div_unit
// Brief  : Iterative shift-add multiplier / restoring divider with HI/LO.
//          Magnitudes are processed for DATA_W steps, then one sign-fix step
//          writes HI/LO and pulses done_o.
// Rev    : 1.0  initial release
// ============================================================================
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int               CNT_W  = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  mdu_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DATA_W-1:0]   r_b;
  // Multiply: {partial sum, multiplier}. Divide: {remainder, quotient}.
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  logic                w_signed;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_div_next;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [2*DATA_W-1:0] w_prod_fix;

  assign w_signed = op_is_signed(op_i);
  assign w_neg_a  = w_signed & rs_data_i[DATA_W-1];
  assign w_neg_b  = w_signed & rt_data_i[DATA_W-1];

  mdu_cond_neg #(.WIDTH(DATA_W)) u_abs_a (.neg_i(w_neg_a), .a_i(rs_data_i), .y_i(w_abs_a));
  mdu_cond_neg #(.WIDTH(DATA_W)) u_abs_b (.neg_i(w_neg_b), .a_i(rt_data_i), .y_i(w_abs_b));

  // Shift-add step: add multiplicand into the upper half when LSB is set, then shift right
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Restoring step: shift next dividend bit into the remainder and trial-subtract.
  // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
  assign w_shift    = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_div_next = w_diff[DATA_W] ? {w_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                     : {w_diff[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};

  mdu_cond_neg #(.WIDTH(DATA_W)) u_quo_fix (
    .neg_i(r_neg_q), .a_i(r_acc[DATA_W-1:0]), .y_i(w_quo_fix));
  mdu_cond_neg #(.WIDTH(DATA_W)) u_rem_fix (
    .neg_i(r_neg_r), .a_i(r_acc[2*DATA_W-1:DATA_W]), .y_i(w_rem_fix));
  mdu_cond_neg #(.WIDTH(2*DATA_W)) u_prod_fix (
    .neg_i(r_neg_q), .a_i(r_acc), .y_i(w_prod_fix));

  // Sequencer: IDLE -> CALC for DATA_W edges -> SIGN for one edge -> IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
          end
        end
        ST_CALC: begin
          if (r_cnt == c_LAST) r_state <= ST_SIGN;
          else                 r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_SIGN: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: latch magnitudes and sign flags at start, iterate during CALC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (r_state == ST_IDLE && start_i) begin
      r_is_div <= op_is_div(op_i);
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      r_b      <= w_abs_b;
      r_acc    <= {{DATA_W{1'b0}}, w_abs_a};
    end else if (r_state == ST_CALC) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
    end
  end

  // HI/LO: MTHI/MTLO only while idle; the SIGN step commits the result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (hi_we_i) r_hi <= wdata_i;
        if (lo_we_i) r_lo <= wdata_i;
      end else if (r_state == ST_SIGN) begin
        r_done <= 1'b1;
        if (r_is_div) begin
          r_lo <= w_quo_fix;
          r_hi <= w_rem_fix;
        end else begin
          {r_hi, r_lo} <= w_prod_fix;
        end
      end
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mult_div_unit
// Brief  : Self-checking bench for mult_div_unit: arithmetic reference model
//          compared every cycle, plus directed literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] rs_data_i;
  logic [W-1:0] rt_data_i;
  logic         hi_we_i;
  logic         lo_we_i;
  logic [W-1:0] wdata_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_pulses = 0;

  always #5 clk_i = ~clk_i;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic
  function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0; l = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin
          h = a;
          l = a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Transaction-level model: a result becomes architecturally visible W+1 edges after start
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_cnt  = 0;
  logic         m_done = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else begin
        if (hi_we_i) m_hi = wdata_i;
        if (lo_we_i) m_lo = wdata_i;
        if (start_i) begin
          model_op(op_i, rs_data_i, rt_data_i, p_hi, p_lo);
          m_cnt = W + 1;
        end
      end
    end
  end

  // Every-cycle compare, sampled just after the active edge
  always @(posedge clk_i) begin
    #1;
    chk("cyc_hi",   64'(hi_o),   64'(m_hi));
    chk("cyc_lo",   64'(lo_o),   64'(m_lo));
    chk("cyc_busy", 64'(busy_o), 64'(m_cnt > 0));
    chk("cyc_done", 64'(done_o), 64'(m_done));
    if (done_o) n_done_pulses++;
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    @(posedge clk_i);
    #2;
    start_i = 1'b0;
  endtask

  // Edges from now until done_o is seen; 0 on timeout
  task automatic wait_done(output int n);
    int i;
    n = 0;
    i = 0;
    while (n == 0 && i < 60) begin
      @(posedge clk_i);
      #2;
      i++;
      if (done_o) n = i;
    end
    if (n == 0) chk("done_timeout", 64'(i), 64'(0));
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    issue(op, a, b);
    wait_done(n);
    chk({nm, "_latency"}, 64'(n), 64'(33));
    chk({nm, "_hi"}, 64'(hi_o), 64'(eh));
    chk({nm, "_lo"}, 64'(lo_o), 64'(el));
    chk({nm, "_busy"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    int n;
    int pulses;
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_hi",   64'(hi_o),   64'(0));
    chk("rst_lo",   64'(lo_o),   64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));

    run_op("mult_neg",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdiv", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",       2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003);
    run_op("divu_zero",  2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_zero",   2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI and MTLO together while idle
    @(negedge clk_i);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_1111;
    @(posedge clk_i); #2;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("mt_both_hi", 64'(hi_o), 64'(32'h0000_1111));
    chk("mt_both_lo", 64'(lo_o), 64'(32'h0000_1111));

    // Write in the start cycle lands, then the result overwrites it
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; rs_data_i = 32'd2; rt_data_i = 32'd3;
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_ABCD;
    @(posedge clk_i); #2;
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("mt_start_hi", 64'(hi_o), 64'(32'h0000_ABCD));
    chk("mt_start_lo", 64'(lo_o), 64'(32'h0000_ABCD));
    wait_done(n);
    chk("mt_start_res_hi", 64'(hi_o), 64'(0));
    chk("mt_start_res_lo", 64'(lo_o), 64'(6));

    // start_i and MTHI while busy are ignored
    issue(2'b00, 32'd2, 32'd3);
    repeat (9) @(posedge clk_i);
    #2;
    start_i = 1'b1; op_i = 2'b11; rs_data_i = 32'd10; rt_data_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
    @(posedge clk_i); #2;
    start_i = 1'b0; hi_we_i = 1'b0;
    chk("busy_mthi_hi", 64'(hi_o), 64'(0));
    wait_done(n);
    chk("busy_ign_latency", 64'(n), 64'(23));
    chk("busy_ign_hi", 64'(hi_o), 64'(0));
    chk("busy_ign_lo", 64'(lo_o), 64'(6));
    @(posedge clk_i); #2;
    chk("busy_ign_no_restart", 64'(busy_o), 64'(0));

    // Asynchronous reset mid-divide drops the operation
    issue(2'b10, 32'd64, 32'd7);
    repeat (14) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_hi",   64'(hi_o),   64'(0));
    chk("arst_lo",   64'(lo_o),   64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_done", 64'(done_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    pulses = n_done_pulses;
    repeat (40) @(posedge clk_i);
    #2;
    chk("arst_no_done", 64'(n_done_pulses), 64'(pulses));
    @(negedge clk_i);
    lo_we_i = 1'b1; wdata_i = 32'h0000_0055;
    @(posedge clk_i); #2;
    lo_we_i = 1'b0;
    chk("arst_mtlo", 64'(lo_o), 64'(32'h0000_0055));
    chk("arst_mtlo_hi", 64'(hi_o), 64'(0));

    repeat (2) @(posedge clk_i);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
